// File: rtl/axi_read_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_read_arbiter_pkg : shared AXI field types and arbitration help |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package axi_read_arbiter_pkg;

  typedef logic [31:0] axi_addr_t;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_RESP_W = 2;

  typedef enum logic [0:0] {
    AR_IDLE   = 1'b0,
    AR_LOCKED = 1'b1
  } ar_state_t;

  // First set bit of vld at or after ptr, wrapping modulo n; ptr if none set.
  function automatic int rr_pick(input logic [15:0] vld, input int ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (vld[idx]) rr_pick = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_grant_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_grant_fifo : in-order FIFO of requester indices per burst      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axi_grant_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  // Full is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
  assign w_push = push && (r_count != c_depth);
  assign w_pop  = pop && (r_count != '0);

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);
  assign count = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_read_arbiter : round-robin N:1 AXI read arbiter, in-order R    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            s_arvalid,
  input  logic [NUM_REQ*AXI_ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*AXI_LEN_W-1:0]  s_arlen,
  input  logic [NUM_REQ*AXI_SIZE_W-1:0] s_arsize,
  output logic [NUM_REQ-1:0]            s_arready,
  output logic [NUM_REQ-1:0]            s_rvalid,
  output logic [WIDTH-1:0]              s_rdata,
  output logic [AXI_RESP_W-1:0]         s_rresp,
  output logic                          s_rlast,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic                          m_arvalid,
  output logic [AXI_ADDR_W-1:0]         m_araddr,
  output logic [AXI_LEN_W-1:0]          m_arlen,
  output logic [AXI_SIZE_W-1:0]         m_arsize,
  input  logic                          m_arready,
  input  logic                          m_rvalid,
  input  logic [WIDTH-1:0]              m_rdata,
  input  logic [AXI_RESP_W-1:0]         m_rresp,
  input  logic                          m_rlast,
  output logic                          m_rready
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

  if (WIDTH < 8 || WIDTH > 1024 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "axi_read_arbiter: WIDTH must be a power of two in 8..1024");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $fatal(1, "axi_read_arbiter: NUM_REQ must be in 2..16");
  end
  if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $fatal(1, "axi_read_arbiter: MAX_OUTSTANDING must be a power of two >= 2");
  end

  ar_state_t        r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_lock_idx;
  logic             r_rst_q;

  logic             w_live;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_grant;
  logic [IDX_W-1:0] w_head;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [CNT_W-1:0] w_count;
  logic             w_ar_fire;
  logic             w_pop;
  axi_addr_t        w_addr;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == c_last_idx) ? '0 : idx + IDX_W'(1);
  endfunction

  // Handshake outputs stay quiet during reset and for one cycle after it.
  assign w_live   = !reset && !r_rst_q;
  assign w_rr_idx = IDX_W'(rr_pick(16'(s_arvalid), int'(r_rr_ptr), NUM_REQ));
  assign w_grant  = (r_state == AR_LOCKED) ? r_lock_idx : w_rr_idx;

  assign m_arvalid = w_live && ((r_state == AR_LOCKED) ? s_arvalid[r_lock_idx]
                                                       : (|s_arvalid && !w_fifo_full));
  assign w_addr    = s_araddr[w_grant*AXI_ADDR_W +: AXI_ADDR_W];
  assign m_araddr  = w_addr;
  assign m_arlen   = s_arlen[w_grant*AXI_LEN_W +: AXI_LEN_W];
  assign m_arsize  = s_arsize[w_grant*AXI_SIZE_W +: AXI_SIZE_W];
  assign w_ar_fire = m_arvalid && m_arready;
  assign s_arready = w_ar_fire ? (NUM_REQ'(1) << w_grant) : '0;

  assign s_rvalid = (w_live && m_rvalid && !w_fifo_empty) ? (NUM_REQ'(1) << w_head) : '0;
  assign m_rready = w_live && !w_fifo_empty && s_rready[w_head];
  assign w_pop    = m_rvalid && m_rready && m_rlast;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  axi_grant_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (IDX_W)
  ) u_grant_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_ar_fire),
    .push_data (w_grant),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= AR_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
      r_rst_q    <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      case (r_state)
        AR_IDLE: begin
          if (m_arvalid) begin
            if (m_arready) begin
              r_rr_ptr <= next_idx(w_rr_idx);
            end else begin
              r_lock_idx <= w_rr_idx;
              r_state    <= AR_LOCKED;
            end
          end
        end
        AR_LOCKED: begin
          if (w_ar_fire) begin
            r_rr_ptr <= next_idx(r_lock_idx);
            r_state  <= AR_IDLE;
          end
        end
        default: r_state <= AR_IDLE;
      endcase
    end
  end

  a_quiet_in_reset: assert property (@(posedge clock) reset |-> (s_arready == '0 && s_rvalid == '0))
    else $error("handshake output asserted during reset");
  a_arready_onehot: assert property (@(posedge clock) $onehot0(s_arready))
    else $error("multiple s_arready");
  a_rvalid_onehot: assert property (@(posedge clock) $onehot0(s_rvalid))
    else $error("multiple s_rvalid");
  a_count_bound: assert property (@(posedge clock) disable iff (reset) w_count <= c_cnt_max)
    else $error("grant FIFO count overflow");
  a_lock_not_full: assert property (@(posedge clock) disable iff (reset)
                                    (r_state == AR_LOCKED) |-> !w_fifo_full)
    else $error("locked with full grant FIFO");
  a_r_orphan: assert property (@(posedge clock) disable iff (reset) !(m_rvalid && w_fifo_empty))
    else $error("R beat with no outstanding AR");

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axi_read_arbiter : directed + random bench with queue model     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_axi_read_arbiter;
  localparam int NR   = 4;
  localparam int W    = 64;
  localparam int MAXO = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   s_arvalid;
  logic [NR*32-1:0] s_araddr;
  logic [NR*8-1:0] s_arlen;
  logic [NR*3-1:0] s_arsize;
  logic [NR-1:0]   s_arready;
  logic [NR-1:0]   s_rvalid;
  logic [W-1:0]    s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [NR-1:0]   s_rready;
  logic            m_arvalid;
  logic [31:0]     m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic            m_arready;
  logic            m_rvalid;
  logic [W-1:0]    m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rready;

  always #5 clock = ~clock;

  axi_read_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding-burst queue of requester indices, rotation pointer, held winner.
  int mq[$];
  int slq[$];
  int mrr = 0;
  int mheld = -1;
  bit rst_prev = 1'b1;
  int slv_beat = 0;

  logic [NR-1:0] obs_arready, obs_rvalid;
  logic          obs_marvalid, obs_mrready;
  logic [31:0]   obs_araddr;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_req(int i, logic [31:0] addr, logic [7:0] len);
    s_arvalid[i]        = 1'b1;
    s_araddr[32*i +: 32] = addr;
    s_arlen[8*i +: 8]    = len;
    s_arsize[3*i +: 3]   = 3'd3;
  endtask

  task automatic present_beat();
    if (!m_rvalid && slq.size() > 0) begin
      m_rvalid = 1'b1;
      m_rdata  = {$urandom, $urandom};
      m_rresp  = 2'($urandom);
      m_rlast  = (slv_beat == slq[0]);
    end
  endtask

  // One clock: check DUT against the model mid-cycle, then advance the model past the edge.
  task automatic tick();
    int g;
    int h;
    bit live, e_arv, fire, nonempty, e_mrr;
    logic [NR-1:0] e_arr, e_rv;
    @(negedge clock);
    live = !reset && !rst_prev;
    g = mheld;
    if (g < 0) begin
      g = mrr;
      for (int k = NR - 1; k >= 0; k--) if (s_arvalid[(mrr + k) % NR]) g = (mrr + k) % NR;
    end
    e_arv    = live && ((mheld >= 0) ? s_arvalid[mheld] : (|s_arvalid && mq.size() < MAXO));
    fire     = e_arv && m_arready;
    e_arr    = fire ? (NR'(1) << g) : '0;
    nonempty = (mq.size() > 0);
    h        = nonempty ? mq[0] : 0;
    e_rv     = (live && m_rvalid && nonempty) ? (NR'(1) << h) : '0;
    e_mrr    = live && nonempty && s_rready[h];

    chk("m_arvalid", m_arvalid, e_arv);
    if (e_arv) begin
      chk("m_araddr", m_araddr, s_araddr[32*g +: 32]);
      chk("m_arlen", m_arlen, s_arlen[8*g +: 8]);
      chk("m_arsize", m_arsize, s_arsize[3*g +: 3]);
    end
    chk("s_arready", s_arready, e_arr);
    chk("s_rvalid", s_rvalid, e_rv);
    chk("m_rready", m_rready, e_mrr);
    if (m_rvalid) begin
      chk("s_rdata", s_rdata, m_rdata);
      chk("s_rresp", s_rresp, m_rresp);
      chk("s_rlast", s_rlast, m_rlast);
    end
    obs_arready  = s_arready;
    obs_rvalid   = s_rvalid;
    obs_marvalid = m_arvalid;
    obs_mrready  = m_rready;
    obs_araddr   = m_araddr;

    @(posedge clock);
    #1;
    if (reset) begin
      mq.delete();
      slq.delete();
      mrr = 0;
      mheld = -1;
      slv_beat = 0;
      m_rvalid = 1'b0;
    end else begin
      if (m_rvalid && e_mrr) begin
        if (m_rlast) begin
          void'(mq.pop_front());
          void'(slq.pop_front());
          slv_beat = 0;
        end else begin
          slv_beat++;
        end
        m_rvalid = 1'b0;
      end
      if (fire) begin
        mq.push_back(g);
        slq.push_back(int'(s_arlen[8*g +: 8]));
        mrr = (g + 1) % NR;
        mheld = -1;
        s_arvalid[g] = 1'b0;
      end else if (e_arv) begin
        mheld = g;
      end
    end
    rst_prev = reset;
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((slq.size() > 0 || s_arvalid != '0) && n < bound) begin
      s_rready  = '1;
      m_arready = 1'b1;
      present_beat();
      tick();
      n++;
    end
    chk("drain_done", 64'(slq.size() == 0 && s_arvalid == '0), 64'd1);
  endtask

  task automatic drive_rand();
    for (int i = 0; i < NR; i++) begin
      if (!s_arvalid[i] && $urandom_range(99) < 30) begin
        set_req(i, $urandom, 8'($urandom_range(3)));
        s_arsize[3*i +: 3] = 3'($urandom_range(7));
      end
      s_rready[i] = ($urandom_range(99) < 70);
    end
    m_arready = 1'($urandom_range(1));
    if ($urandom_range(99) < 60) present_beat();
  endtask

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 32'h1000 * (i + 1), 8'd0);

    // Reset and the quiet cycle after it
    tick();
    chk("rst_arvalid", obs_marvalid, 1'b0);
    reset = 1'b0;
    m_arready = 1'b1;
    tick();
    chk("post_rst_arvalid", obs_marvalid, 1'b0);

    // Round-robin with all requesters valid
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < NR; i++) set_req(i, 32'h1000 * (i + 1), 8'd0);
      tick();
      chk("rr_grant", obs_arready, NR'(1) << exp_rr[n]);
    end
    s_arvalid = '0;
    m_arready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      s_rready = '1;
      present_beat();
      tick();
      chk("rr_route", obs_rvalid, NR'(1) << exp_rr[n]);
    end

    // In-order routing of a 4-beat burst followed by a single beat
    m_arready = 1'b1;
    set_req(2, 32'h2222_0000, 8'd3);
    tick();
    chk("ar_req2", obs_arready, 4'b0100);
    set_req(0, 32'h0000_0040, 8'd0);
    tick();
    chk("ar_req0", obs_arready, 4'b0001);
    m_arready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      s_rready = '1;
      present_beat();
      tick();
      chk("burst_route", obs_rvalid, (n < 4) ? 4'b0100 : 4'b0001);
    end

    // Fill the grant FIFO, then overlap a pop with a new request
    m_arready = 1'b1;
    for (int n = 0; n < MAXO; n++) begin
      set_req(3, 32'h3000 + 32'(n), 8'd0);
      tick();
      chk("fill_grant", obs_arready, 4'b1000);
    end
    set_req(3, 32'h3999, 8'd0);
    tick();
    chk("full_hold", obs_marvalid, 1'b0);
    s_rready = '1;
    present_beat();
    tick();
    chk("full_pop_arvalid", obs_marvalid, 1'b0);
    chk("full_pop_rready", obs_mrready, 1'b1);
    tick();
    chk("after_pop_arvalid", obs_marvalid, 1'b1);
    chk("after_pop_grant", obs_arready, 4'b1000);
    drain(100);

    // Grant lock: req1 held while req0 joins later
    m_arready = 1'b0;
    set_req(1, 32'hA1A1_0001, 8'd0);
    tick();
    chk("lock_addr1", obs_araddr, 32'hA1A1_0001);
    set_req(0, 32'hB0B0_0000, 8'd0);
    tick();
    chk("lock_addr2", obs_araddr, 32'hA1A1_0001);
    tick();
    chk("lock_addr3", obs_araddr, 32'hA1A1_0001);
    m_arready = 1'b1;
    tick();
    chk("lock_fire", obs_arready, 4'b0010);
    tick();
    chk("lock_next", obs_arready, 4'b0001);
    drain(50);

    // R backpressure on the head requester
    set_req(3, 32'h3333_0000, 8'd0);
    tick();
    chk("bp_ar", obs_arready, 4'b1000);
    m_arready = 1'b0;
    s_rready = 4'b0111;
    present_beat();
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_rvalid", obs_rvalid, 4'b1000);
      chk("bp_rready", obs_mrready, 1'b0);
    end
    s_rready = '1;
    tick();
    chk("bp_accept", obs_mrready, 1'b1);

    // Reset with three bursts in flight
    m_arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(i, 32'h5000 + 32'(i), 8'd1);
      tick();
    end
    reset = 1'b1;
    m_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    set_req(1, 32'h6000_0001, 8'd0);
    tick();
    chk("mid_rst_arvalid", obs_marvalid, 1'b0);
    chk("mid_rst_rvalid", obs_rvalid, 4'b0000);
    tick();
    chk("mid_rst_fire", obs_arready, 4'b0010);
    drain(50);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      drive_rand();
      if ($urandom_range(399) == 0) begin
        reset = 1'b1;
        m_rvalid = 1'b0;
      end else begin
        reset = 1'b0;
      end
      tick();
    end
    reset = 1'b0;
    drain(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
Shares one AXI read port among NUM_REQ requesters. The shared port is a single-ID, in-order port, such as the DPI-backed read slave in the testbench.
- AR channel: round-robin arbitration, with the grant locked until the handshake completes.
- R channel: beats are routed back by an in-order grant FIFO.
- Placement: sits between the T1 memory-side masters (e.g. scalar core, vector LSU) and the single memory read port.

Parameters:
NUM_REQ, 4, number of requesters; 2..16.
WIDTH, 64, R data width; one of 8..1024 (powers of two); elaboration fatal otherwise.
MAX_OUTSTANDING, 8, maximum accepted-but-uncompleted bursts; power of two, ≥2.
IDX_W, $clog2(NUM_REQ), derived localparam: requester index width.

Ports:
clock  in  1  sole clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
s_arvalid  in  NUM_REQ  per-requester AR valid.
s_araddr  in  NUM_REQ*32  per-requester AR address; packed, requester i at [32i+:32].
s_arlen  in  NUM_REQ*8  per-requester burst length minus 1.
s_arsize  in  NUM_REQ*3  per-requester beat size.
s_arready  out  NUM_REQ  per-requester AR ready.
s_rvalid  out  NUM_REQ  per-requester R valid.
s_rdata  out  WIDTH  shared R data, broadcast to all requesters.
s_rresp  out  2  shared R response, broadcast.
s_rlast  out  1  shared R last, broadcast.
s_rready  in  NUM_REQ  per-requester R ready.
m_arvalid  out  1  downstream AR valid.
m_araddr  out  32  downstream AR address.
m_arlen  out  8  downstream burst length minus 1.
m_arsize  out  3  downstream beat size.
m_arready  in  1  downstream AR ready.
m_rvalid  in  1  downstream R valid.
m_rdata  in  WIDTH  downstream R data.
m_rresp  in  2  downstream R response.
m_rlast  in  1  downstream R last.
m_rready  out  1  downstream R ready.

Behaviour:
- Timing: single clock; reset is synchronous and active-high. Both channel paths are combinational (zero latency); only arbitration state and the FIFO are registered.
- Reset values:
  - state=IDLE, rr_ptr=0, lock_idx=0, FIFO empty (count=0).
  - Outputs follow from state: m_arvalid=0, s_arready=0, s_rvalid=0, m_rready=0 while reset is high and on the first cycle after it.
- AR FSM, two states, IDLE and LOCKED:
  - IDLE, grant selection: g = first i with s_arvalid[i], scanning from rr_ptr upward modulo NUM_REQ.
  - IDLE, drive: m_arvalid = any(s_arvalid) && !fifo_full; m_ar* = requester g fields.
  - IDLE, on fire (m_arvalid && m_arready): push g, rr_ptr <= g+1 mod NUM_REQ, stay IDLE.
  - IDLE, valid without ready: lock_idx <= g, go to LOCKED.
  - LOCKED: grant fixed at lock_idx; m_arvalid = s_arvalid[lock_idx]. Requesters obey AXI valid-stability, so this stays asserted.
  - LOCKED, on fire: push lock_idx, rr_ptr <= lock_idx+1, go to IDLE.
  - LOCKED and full cannot coexist: lock is only entered when the FIFO is not full, and only AR pushes. An internal assertion checks this.
- AR ready: s_arready[i] = m_arready && m_arvalid && (granted index == i).
- Priority rotation: rr_ptr only advances on fire. A requester with a lower index than a locked winner waits even if it became valid later.
- R routing:
  - h = FIFO head. s_rvalid[i] = m_rvalid && !fifo_empty && (h == i).
  - m_rready = !fifo_empty && s_rready[h].
  - Pop on m_rvalid && m_rready && m_rlast. Non-last beats do not pop.
- Empty FIFO with m_rvalid=1: m_rready=0 (the beat stalls downstream) and an assertion fires ("R beat with no outstanding AR").
- Full FIFO: m_arvalid is forced to 0 in IDLE. No bypass: a push is allowed only if count < MAX_OUTSTANDING at the start of the cycle, even when a pop occurs the same cycle.
- Same-cycle push and pop: both take effect; count unchanged. Read and write pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: all state is cleared next edge; in-flight bursts are discarded. Environment must quiesce the downstream port.
- Assertions: no s_arready or s_rvalid during reset; onehot0(s_arready); onehot0(s_rvalid); count <= MAX_OUTSTANDING.

Decomposition:
- Shared package: add to t1_common a typedef axi_addr_t (uint32_t). Add constants for AXI field widths: AXI_LEN_W=8, AXI_SIZE_W=3, AXI_RESP_W=2.
- Sub-module axi_grant_fifo: synchronous FIFO of IDX_W-bit indices with depth MAX_OUTSTANDING.
  - Ports: clock, reset, push/push_data, pop, head, empty, full, count.
  - Arbiter and FSM stay in axi_read_arbiter.

Test Plan:
1. Round-robin AR: NUM_REQ=4, all four s_arvalid held, m_arready=1 → grants in order 0,1,2,3,0. rr_ptr advances by 1 per fire; FIFO contents 0,1,2,3.
2. Grant lock: req1 valid, m_arready=0 for 3 cycles; req0 asserts valid in cycle 2 → m_araddr stays req1's. req1 fires in cycle 4, then req2 if valid, otherwise req0.
3. In-order R routing: AR req2 (arlen=3), then req0 (arlen=0); downstream returns 4+1 beats → s_rvalid[2] for beats 1-4, pop on beat 4's rlast, then s_rvalid[0] for 1 beat; FIFO empty afterwards.
4. Full and backpressure: MAX_OUTSTANDING=8, 8 single-beat ARs with no R → 9th held (m_arvalid=0). A pop and the 9th AR in the same cycle → no push that cycle; push next cycle; count stays 8.
5. R backpressure: head req3 with s_rready[3]=0 for 5 cycles → m_rready=0 and the beat is held. Other requesters' s_rvalid stay 0; the beat is accepted the cycle s_rready[3]=1.
6. Reset mid-burst: 3 outstanding, reset high for 1 cycle → next cycle count=0, m_arvalid=0, s_rvalid=0, rr_ptr=0. A subsequent AR from req1 fires normally.
